// File: rtl/count_pwm_gen_if.sv
// Signal bundle between the counter/duty source and the PWM generator.
// The master drives the count and duty strobes; the slave returns PWM and status.
interface count_pwm_gen_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0] count_in;
   logic [WIDTH-1:0] duty_in;
   logic             duty_load;
   logic             pwm_out;
   logic             period_done;
   logic [WIDTH-1:0] duty_active;
   logic             pending;
   logic             stall;
   logic [1:0]       state;

   modport master (
      output count_in, duty_in, duty_load,
      input  pwm_out, period_done, duty_active, pending, stall, state
   );

   modport slave (
      input  count_in, duty_in, duty_load,
      output pwm_out, period_done, duty_active, pending, stall, state
   );
endinterface

// File: rtl/count_pwm_gen.sv
// PWM generator driven by a free-running up-counter, with a double-buffered duty
// register that updates at the counter wrap, a wrap strobe and a stall detector.
module count_pwm_gen #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned STALL_CYC = 16
) (
   input logic            clk,
   input logic            reset,
   count_pwm_gen_if.slave bus_io
);
   localparam int unsigned StallW = (STALL_CYC > 2) ? $clog2(STALL_CYC) : 1;
   localparam logic [StallW-1:0] StallMax = StallW'(STALL_CYC - 1);
   localparam logic [WIDTH-1:0] CountMax = '1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArmed = 2'd1,
      StRun   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  prev_count_q;
   logic [WIDTH-1:0]  duty_active_q, duty_active_d;
   logic [WIDTH-1:0]  pending_duty_q, pending_duty_d;
   logic              pending_q, pending_d;
   logic [StallW-1:0] stall_cnt_q, stall_cnt_d;
   logic              stall_q, stall_d;
   logic              pwm_q, pwm_d;
   logic              period_done_q;
   logic              same;
   logic              wrap;

   assign same = (bus_io.count_in == prev_count_q);
   assign wrap = (prev_count_q == CountMax) && (bus_io.count_in == '0);

   // Saturating run-length of identical samples; stall when the held value
   // has been seen STALL_CYC times in a row.
   always_comb begin
      stall_cnt_d = '0;
      if (same) begin
         stall_cnt_d = (stall_cnt_q == StallMax) ? StallMax : stall_cnt_q + StallW'(1);
      end
      stall_d = same && (stall_cnt_d == StallMax);
   end

   // A load coinciding with a wrap bypasses the pending buffer so the newest
   // value is the one applied to count 0 of the new period.
   always_comb begin
      duty_active_d  = duty_active_q;
      pending_duty_d = pending_duty_q;
      pending_d      = pending_q;
      if (bus_io.duty_load && wrap) begin
         duty_active_d = bus_io.duty_in;
         pending_d     = 1'b0;
      end else if (bus_io.duty_load) begin
         pending_duty_d = bus_io.duty_in;
         pending_d      = 1'b1;
      end else if (wrap && pending_q) begin
         duty_active_d = pending_duty_q;
         pending_d     = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus_io.duty_load) state_d = StArmed;
         StArmed: if (wrap)             state_d = StRun;
         StRun:   if (stall_d)          state_d = StArmed;
         default:                       state_d = StIdle;
      endcase
      pwm_d = (state_d == StRun) && (bus_io.count_in < duty_active_d) && !stall_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= StIdle;
         prev_count_q   <= '0;
         duty_active_q  <= '0;
         pending_duty_q <= '0;
         pending_q      <= 1'b0;
         stall_cnt_q    <= '0;
         stall_q        <= 1'b0;
         pwm_q          <= 1'b0;
         period_done_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         prev_count_q   <= bus_io.count_in;
         duty_active_q  <= duty_active_d;
         pending_duty_q <= pending_duty_d;
         pending_q      <= pending_d;
         stall_cnt_q    <= stall_cnt_d;
         stall_q        <= stall_d;
         pwm_q          <= pwm_d;
         period_done_q  <= wrap;
      end
   end

   assign bus_io.pwm_out     = pwm_q;
   assign bus_io.period_done = period_done_q;
   assign bus_io.duty_active = duty_active_q;
   assign bus_io.pending     = pending_q;
   assign bus_io.stall       = stall_q;
   assign bus_io.state       = state_q;
endmodule
